soc_reset_sequencer: RTL and testbench
======================================

// Module: soc_reset_sequencer
// PURPOSE
//  Sequences the SoC reset upstream of picorv32_wb_soc. Holds soc_reset high until the PLL
//  is stably locked and a hold-off count has elapsed. Re-asserts soc_reset on a debounced
//  key press or on loss of lock, and records the cause of the most recent reset for a status LED.
// PARAMETERS
//  HOLD_CYCLES      256    clocks soc_reset stays high after lock before release (>=2)
//  DEBOUNCE_CYCLES  10000  consecutive stable samples needed to accept a key change (1 ms @ 10 MHz)
//  KEY_ACTIVE_LOW   1      1: key_i low = pressed; 0: key_i high = pressed
//  WDT_CYCLES       2**24  watchdog timeout in clocks (used only with the macro)
// PORTS
//  clock       in   1  system clock (PLL c0, 10 MHz)
//  reset       in   1  synchronous, active-high sequencer reset
//  pll_locked  in   1  PLL lock, asynchronous; 2-FF synchronised internally
//  key_i       in   1  raw push-button, asynchronous; 2-FF synchronised, then debounced
//  wdt_kick    in   1  1-cycle watchdog service strobe; ignored without the macro
//  soc_reset   out  1  registered active-high reset to the SoC
//  rst_cause   out  2  00 power-on, 01 key, 10 lock lost, 11 watchdog
//  rst_count   out  8  resets issued since reset (counts RUN exits), saturates at 255
// BEHAVIOUR
//  - Reset values: soc_reset=1, rst_cause=00, rst_count=0, state=ASSERT, all counters 0,
//    sync FFs cleared, debounced key = released.
//  - soc_reset is registered: soc_reset <= (next_state != RUN).
//  - ASSERT: leave when the debounced key is released -> WAIT_LOCK. Lasts at least 1 cycle.
//    A held key keeps the sequencer in ASSERT.
//  - WAIT_LOCK: on lock_s=1 -> HOLD, with hold_cnt=0.
//  - HOLD: hold_cnt increments every cycle.
//    - lock_s=0 -> WAIT_LOCK; hold_cnt is cleared.
//    - hold_cnt==HOLD_CYCLES-1 -> RUN.
//  - Latency: let edge 0 be the first edge that samples pll_locked=1. soc_reset is low after
//    edge 2+HOLD_CYCLES.
//  - RUN exit priority when events coincide: key press > lock loss > watchdog.
//    - Key press (debounced release->pressed transition) -> ASSERT, cause 01.
//    - lock_s=0 -> WAIT_LOCK, cause 10.
//    - Watchdog timeout -> ASSERT, cause 11.
//    - Every RUN exit increments rst_count (saturating).
//  - Key press in WAIT_LOCK or HOLD -> ASSERT, cause 01; rst_count unchanged.
//  - Debounce: the debounced level changes only after DEBOUNCE_CYCLES consecutive synced
//    samples that differ from it. Any matching sample clears the counter.
//  - reset asserted mid-sequence: full return to the reset values on the next edge.
//  - rst_cause holds its value until the next reset event.
// CONFIGURATION
//  SOC_RESET_SEQ_WDT_EN defined: watchdog counter is active only in RUN.
//    - Cleared on wdt_kick and in every other state.
//    - Reaching WDT_CYCLES-1 without a kick is a timeout.
//    - A kick on the terminal cycle wins: no timeout.
//  Not defined: no watchdog counter, wdt_kick ignored, cause 11 never produced.
// STRUCTURE
//  soc_reset_seq_defs.vh: state encodings (ASSERT, WAIT_LOCK, HOLD, RUN) and cause codes
//  (CAUSE_POR, CAUSE_KEY, CAUSE_LOCK, CAUSE_WDT).
//  Sub-module key_debounce (clock, reset, raw, level): 2-FF sync plus DEBOUNCE_CYCLES filter;
//  polarity is handled in the parent.
//  Parent holds the lock synchroniser, FSM, hold/watchdog counters and status registers.
// TESTING (HOLD_CYCLES=16, DEBOUNCE_CYCLES=8, WDT_CYCLES=64)
//  1. reset 3 cycles, key released, pll_locked=1 from edge 0 -> soc_reset low after edge 18;
//     rst_cause=00; rst_count=0.
//  2. pll_locked drops at hold_cnt=10, returns 5 clocks later -> soc_reset stays 1; a fresh
//     16-cycle hold runs before release.
//  3. In RUN, key pressed 5 clocks then released -> no reset. Key pressed 20 clocks ->
//     soc_reset=1 after sync+8 clocks and held until debounced release, then a new lock/hold
//     sequence; rst_cause=01, rst_count=1.
//  4. In RUN, pll_locked=0 -> soc_reset=1 after 3 edges; rst_cause=10, rst_count increments.
//  5. Key press and lock loss qualify in the same RUN cycle -> rst_cause=01, next state ASSERT.
//  6. WDT_EN: kick every 50 clocks -> no reset; stop kicking -> soc_reset=1 64 clocks after
//     the last kick, rst_cause=11. A kick on cycle 63 -> no reset. Without WDT_EN, no kicks
//     for 1000 clocks -> soc_reset stays 0.

Source files
------------

// File: rtl/soc_reset_sequencer_pkg.sv
// Shared state encodings, reset-cause codes and helpers for the SoC reset sequencer.
package soc_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'b00,
    ST_WAIT_LOCK = 2'b01,
    ST_HOLD      = 2'b10,
    ST_RUN       = 2'b11
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_KEY  = 2'b01;
  localparam logic [1:0] CAUSE_LOCK = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'h01;
    end
  endfunction

endpackage

// File: rtl/soc_reset_sequencer_key_debounce.sv
// Push-button conditioner: 2-FF synchroniser followed by a consecutive-sample filter.
// Input is already polarity-corrected (1 = pressed); level resets to released.
module key_debounce
  import soc_reset_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level; any agreeing sample restarts.
  always_comb begin
    level_d = level_q;
    cnt_d   = CNT_ZERO;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = CNT_ZERO;
      end else begin
        cnt_d   = cnt_q + CW'(1'b1);
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/soc_reset_sequencer.sv
// SoC reset sequencer: holds soc_reset until PLL lock plus hold-off, re-asserts on key/lock loss.
// Optional watchdog enabled by defining SOC_RESET_SEQ_WDT_EN.
module soc_reset_sequencer
  import soc_reset_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = 256,
  parameter int unsigned DEBOUNCE_CYCLES = 10000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter int unsigned WDT_CYCLES      = 2**24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       key_i,
  input  logic       wdt_kick,
  output logic       soc_reset,
  output logic [1:0] rst_cause,
  output logic [7:0] rst_count
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_ZERO = {HW{1'b0}};
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic          lock_meta_q, lock_s_q;
  logic          key_pressed_raw_s, key_lvl_s, key_prev_q, key_press_s;
  logic          wdt_timeout_s;
  state_e        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          soc_reset_q, soc_reset_d;
  logic [1:0]    cause_q, cause_d;
  logic [7:0]    count_q, count_d;

  assign key_pressed_raw_s = KEY_ACTIVE_LOW ? ~key_i : key_i;
  assign key_press_s       = key_lvl_s & ~key_prev_q;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clock(clock),
    .reset(reset),
    .raw  (key_pressed_raw_s),
    .level(key_lvl_s)
  );

`ifdef SOC_RESET_SEQ_WDT_EN
  localparam int unsigned WW = $clog2(WDT_CYCLES);
  localparam logic [WW-1:0] WDT_ZERO = {WW{1'b0}};
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] wdt_cnt_q, wdt_cnt_d;

  // A kick on the terminal count suppresses the timeout.
  always_comb begin
    if ((state_q != ST_RUN) || wdt_kick) begin
      wdt_cnt_d = WDT_ZERO;
    end else begin
      wdt_cnt_d = wdt_cnt_q + WW'(1'b1);
    end
  end

  assign wdt_timeout_s = (state_q == ST_RUN) && !wdt_kick && (wdt_cnt_q == WDT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      wdt_cnt_q <= WDT_ZERO;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
    end
  end
`else
  logic wdt_unused_s;
  assign wdt_unused_s  = wdt_kick ^ (WDT_CYCLES == 32'd0);
  assign wdt_timeout_s = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      key_prev_q  <= 1'b0;
      state_q     <= ST_ASSERT;
      hold_cnt_q  <= HOLD_ZERO;
      soc_reset_q <= 1'b1;
      cause_q     <= CAUSE_POR;
      count_q     <= 8'h00;
    end else begin
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
      key_prev_q  <= key_lvl_s;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      soc_reset_q <= soc_reset_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
    end
  end

  // Exit priority out of the active states: key press, then lock loss, then watchdog.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = HOLD_ZERO;
    case (state_q)
      ST_ASSERT: begin
        if (!key_lvl_s) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          state_d = ST_ASSERT;
        end
      end
      ST_WAIT_LOCK: begin
        if (key_press_s) begin
          state_d = ST_ASSERT;
        end else if (lock_s_q) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_HOLD: begin
        if (key_press_s) begin
          state_d = ST_ASSERT;
        end else if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d    = ST_HOLD;
          hold_cnt_d = hold_cnt_q + HW'(1'b1);
        end
      end
      ST_RUN: begin
        if (key_press_s) begin
          state_d = ST_ASSERT;
        end else if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
        end else if (wdt_timeout_s) begin
          state_d = ST_ASSERT;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase
  end

  always_comb begin
    soc_reset_d = (state_d != ST_RUN);
    if (key_press_s && (state_q != ST_ASSERT)) begin
      cause_d = CAUSE_KEY;
    end else if ((state_q == ST_RUN) && !lock_s_q) begin
      cause_d = CAUSE_LOCK;
    end else if ((state_q == ST_RUN) && wdt_timeout_s) begin
      cause_d = CAUSE_WDT;
    end else begin
      cause_d = cause_q;
    end
    if ((state_q == ST_RUN) && (state_d != ST_RUN)) begin
      count_d = sat_inc8(count_q);
    end else begin
      count_d = count_q;
    end
  end

  assign soc_reset = soc_reset_q;
  assign rst_cause = cause_q;
  assign rst_count = count_q;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Directed bench for soc_reset_sequencer (HOLD=16, DEBOUNCE=8, WDT=64); key is active low.
module tb_soc_reset_sequencer;

  logic       clock;
  logic       reset;
  logic       pll_locked;
  logic       key_i;
  logic       wdt_kick;
  logic       soc_reset;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;

  int errors;
  int checks;

  soc_reset_sequencer #(
    .HOLD_CYCLES    (16),
    .DEBOUNCE_CYCLES(8),
    .KEY_ACTIVE_LOW (1'b1),
    .WDT_CYCLES     (64)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pll_locked(pll_locked),
    .key_i     (key_i),
    .wdt_kick  (wdt_kick),
    .soc_reset (soc_reset),
    .rst_cause (rst_cause),
    .rst_count (rst_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    reset      = 1'b1;
    pll_locked = 1'b1;
    key_i      = 1'b1;
    wdt_kick   = 1'b0;

    // 1: power-on sequence, lock present from edge 0
    repeat (3) @(posedge clock);
    #1;
    check("por_soc_reset", int'(soc_reset), 1);
    check("por_cause", int'(rst_cause), 0);
    check("por_count", int'(rst_count), 0);
    reset = 1'b0;
    tick(18);
    check("t1_high_edge17", int'(soc_reset), 1);
    tick(1);
    check("t1_low_edge18", int'(soc_reset), 0);
    check("t1_cause", int'(rst_cause), 0);
    check("t1_count", int'(rst_count), 0);

    // 2: lock glitch during hold restarts the hold-off
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(13);
    pll_locked = 1'b0;
    tick(5);
    pll_locked = 1'b1;
    tick(1);
    check("t2_high_edge18", int'(soc_reset), 1);
    tick(17);
    check("t2_high_edge35", int'(soc_reset), 1);
    tick(1);
    check("t2_low_edge36", int'(soc_reset), 0);

    // 3: short press rejected, long press resets the SoC
    key_i = 1'b0;
    tick(5);
    key_i = 1'b1;
    tick(20);
    check("t3_short_press", int'(soc_reset), 0);
    check("t3_short_count", int'(rst_count), 0);
    key_i = 1'b0;
    tick(10);
    check("t3_press_k9", int'(soc_reset), 0);
    tick(1);
    check("t3_press_k10", int'(soc_reset), 1);
    check("t3_cause", int'(rst_cause), 1);
    check("t3_count", int'(rst_count), 1);
    tick(9);
    key_i = 1'b1;
    tick(27);
    check("t3_rel_r26", int'(soc_reset), 1);
    tick(1);
    check("t3_rel_r27", int'(soc_reset), 0);

    // 4: lock loss in RUN
    pll_locked = 1'b0;
    tick(2);
    check("t4_lock_e1", int'(soc_reset), 0);
    tick(1);
    check("t4_lock_e2", int'(soc_reset), 1);
    check("t4_cause", int'(rst_cause), 2);
    check("t4_count", int'(rst_count), 2);
    pll_locked = 1'b1;
    tick(18);
    check("t4_relock_high", int'(soc_reset), 1);
    tick(1);
    check("t4_relock_low", int'(soc_reset), 0);

    // 5: key press and lock loss qualify in the same RUN cycle
    key_i = 1'b0;
    tick(8);
    pll_locked = 1'b0;
    tick(2);
    check("t5_k9", int'(soc_reset), 0);
    tick(1);
    check("t5_k10", int'(soc_reset), 1);
    check("t5_cause", int'(rst_cause), 1);
    check("t5_count", int'(rst_count), 3);
    pll_locked = 1'b1;
    tick(30);
    check("t5_held_in_assert", int'(soc_reset), 1);
    key_i = 1'b1;
    tick(27);
    check("t5_rel_r26", int'(soc_reset), 1);
    tick(1);
    check("t5_rel_r27", int'(soc_reset), 0);

    // 6: watchdog
`ifdef SOC_RESET_SEQ_WDT_EN
    for (int i = 0; i < 4; i++) begin
      wdt_kick = 1'b1;
      tick(1);
      wdt_kick = 1'b0;
      tick(49);
    end
    check("t6_kicked", int'(soc_reset), 0);
    wdt_kick = 1'b1;
    tick(1);
    wdt_kick = 1'b0;
    tick(63);
    check("t6_wdt_63", int'(soc_reset), 0);
    tick(1);
    check("t6_wdt_64", int'(soc_reset), 1);
    check("t6_wdt_cause", int'(rst_cause), 3);
    check("t6_wdt_count", int'(rst_count), 4);
    tick(17);
    check("t6_recover_high", int'(soc_reset), 1);
    tick(1);
    check("t6_recover_low", int'(soc_reset), 0);
    wdt_kick = 1'b1;
    tick(1);
    wdt_kick = 1'b0;
    tick(63);
    wdt_kick = 1'b1;
    tick(1);
    wdt_kick = 1'b0;
    check("t6_term_kick", int'(soc_reset), 0);
    tick(40);
    check("t6_term_kick_after", int'(soc_reset), 0);
    check("t6_term_count", int'(rst_count), 4);
`else
    tick(1000);
    check("t6_no_wdt", int'(soc_reset), 0);
    check("t6_no_wdt_cause", int'(rst_cause), 1);
    check("t6_no_wdt_count", int'(rst_count), 3);
`endif

    // reset mid-run returns everything to reset values
    reset = 1'b1;
    tick(1);
    check("rst_mid_soc_reset", int'(soc_reset), 1);
    check("rst_mid_cause", int'(rst_cause), 0);
    check("rst_mid_count", int'(rst_count), 0);
    reset = 1'b0;
    tick(1);
    check("rst_mid_after", int'(soc_reset), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
